// File: rtl/writeback_queue.sv
// In-order result buffer that merges the ALU and load result streams into the
// register file's single write port, with two pending/bypass lookup ports.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [AW-1:0]                alu_rd,
    input  logic [DW-1:0]                alu_data,
    input  logic                         ld_valid,
    input  logic [AW-1:0]                ld_rd,
    input  logic [DW-1:0]                ld_data,
    output logic                         in_ready,
    input  logic                         wb_stall,
    output logic                         write_enable,
    output logic [AW-1:0]                write_address,
    output logic [DW-1:0]                data_in,
    input  logic [AW-1:0]                rs1_addr,
    input  logic [AW-1:0]                rs2_addr,
    output logic                         rs1_pending,
    output logic                         rs2_pending,
    output logic [DW-1:0]                rs1_fwd,
    output logic [DW-1:0]                rs2_fwd,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Entry storage stays in flops: every entry is compared by the lookups each cycle.
    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic          alu_enq, ld_enq, deq;
    logic [PW-1:0] ld_slot;
    logic [1:0]    enq_count;
    logic          not_empty;

    assign not_empty = (count_reg != '0);
    assign in_ready  = (count_reg <= CW'(DEPTH - 2));

    // Results offered while not ready are dropped; reset also blocks enqueue.
    assign alu_enq   = alu_valid && in_ready && !rst;
    assign ld_enq    = ld_valid  && in_ready && !rst;
    assign ld_slot   = tail_reg + PW'(alu_enq);
    assign enq_count = {1'b0, alu_enq} + {1'b0, ld_enq};
    assign deq       = not_empty && !wb_stall && !rst;

    assign head_next  = head_reg + PW'(deq);
    assign tail_next  = tail_reg + PW'(enq_count);
    assign count_next = count_reg + CW'(enq_count) - CW'(deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_enq) begin
            rd_mem[tail_reg]   <= alu_rd;
            data_mem[tail_reg] <= alu_data;
        end
        if (ld_enq) begin
            rd_mem[ld_slot]   <= ld_rd;
            data_mem[ld_slot] <= ld_data;
        end
    end

    assign write_enable  = deq;
    assign write_address = not_empty ? rd_mem[head_reg]   : '0;
    assign data_in       = not_empty ? data_mem[head_reg] : '0;
    assign count         = count_reg;

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
        logic [AW-1:0] addr;
        logic          hit;
        logic [DW-1:0] val;

        assign addr = (gi == 0) ? rs1_addr : rs2_addr;

        always_comb begin
            hit = 1'b0;
            val = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_reg) && (rd_mem[head_reg + PW'(i)] == addr)) begin
                    hit = 1'b1;
                    val = data_mem[head_reg + PW'(i)];
                end
            end
        end
    end

    assign rs1_pending = g_lookup[0].hit;
    assign rs1_fwd     = g_lookup[0].val;
    assign rs2_pending = g_lookup[1].hit;
    assign rs2_fwd     = g_lookup[1].val;
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a reference queue of expected writes is
// advanced every cycle and all DUT outputs are compared against it.
module tb_writeback_queue;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, ld_valid, wb_stall;
    logic [AW-1:0] alu_rd, ld_rd, rs1_addr, rs2_addr;
    logic [DW-1:0] alu_data, ld_data;
    logic          in_ready, write_enable, rs1_pending, rs2_pending;
    logic [AW-1:0] write_address;
    logic [DW-1:0] data_in, rs1_fwd, rs2_fwd;
    logic [2:0]    count;

    int errors = 0;
    int checks = 0;
    int rd9_writes = 0;
    entry_t sb_q[$];

    writeback_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .in_ready(in_ready), .wb_stall(wb_stall),
        .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
        wb_stall  = 0;
    endtask

    task automatic lookup(input logic [AW-1:0] a, output logic p, output logic [DW-1:0] f);
        p = 1'b0;
        f = '0;
        foreach (sb_q[i]) begin
            if (sb_q[i].rd == a) begin
                p = 1'b1;
                f = sb_q[i].data;
            end
        end
    endtask

    // Check outputs on the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic          exp_we, exp_rdy, p1, p2;
        logic [DW-1:0] f1, f2;
        entry_t        hd;
        @(negedge clk);
        exp_rdy = (sb_q.size() <= 2);
        exp_we  = !rst && (sb_q.size() > 0) && !wb_stall;
        hd      = (sb_q.size() > 0) ? sb_q[0] : '0;
        lookup(rs1_addr, p1, f1);
        lookup(rs2_addr, p2, f2);
        check("count", 64'(count), 64'(sb_q.size()));
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("write_enable", 64'(write_enable), 64'(exp_we));
        check("write_address", 64'(write_address), 64'(hd.rd));
        check("data_in", 64'(data_in), 64'(hd.data));
        check("rs1_pending", 64'(rs1_pending), 64'(p1));
        check("rs1_fwd", 64'(rs1_fwd), 64'(f1));
        check("rs2_pending", 64'(rs2_pending), 64'(p2));
        check("rs2_fwd", 64'(rs2_fwd), 64'(f2));
        if (write_enable && write_address == 5'd9) rd9_writes++;
        $display("t=%0t rst=%0b alu=%0b/%0d/%0h ld=%0b/%0d/%0h stall=%0b count=%0d we=%0b wa=%0d wd=%0h",
                 $time, rst, alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
                 wb_stall, count, write_enable, write_address, data_in);
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
        end else begin
            if (exp_we) void'(sb_q.pop_front());
            if (exp_rdy && alu_valid) sb_q.push_back({alu_rd, alu_data});
            if (exp_rdy && ld_valid)  sb_q.push_back({ld_rd, ld_data});
        end
        #1;
    endtask

    task automatic push_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
        alu_valid = 1; alu_rd = r; alu_data = d;
    endtask

    task automatic push_ld(input logic [AW-1:0] r, input logic [DW-1:0] d);
        ld_valid = 1; ld_rd = r; ld_data = d;
    endtask

    initial begin
        idle();
        rs1_addr = '0; rs2_addr = '0;
        rst = 1;
        step(); step();
        rst = 0;
        repeat (3) step();

        // Single result, empty queue: visible one cycle after enqueue.
        rs1_addr = 5;
        push_alu(5, 32'hDEADBEEF); step();
        idle(); repeat (2) step();

        // Dual issue to the same register: load is younger.
        rs1_addr = 3; rs2_addr = 0;
        push_alu(3, 32'h11); push_ld(3, 32'h22); step();
        idle(); repeat (3) step();

        // Stalled fill to 3, rejected push, then drain.
        rs1_addr = 10; rs2_addr = 12;
        for (int i = 0; i < 4; i++) begin
            idle(); wb_stall = 1; push_alu(AW'(10 + i), DW'(32'hA0 + i)); step();
        end
        idle(); repeat (4) step();

        // Stalled fill to 4 via a dual push at count 2, rejected push at full.
        rs1_addr = 0; rs2_addr = 1;
        idle(); wb_stall = 1; push_alu(1, 32'hB0); step();
        idle(); wb_stall = 1; push_ld(0, 32'hB1); step();
        idle(); wb_stall = 1; push_alu(1, 32'hB2); push_ld(0, 32'hB3); step();
        idle(); wb_stall = 1; push_ld(1, 32'hB4); step();
        idle(); wb_stall = 1; step();
        idle(); repeat (5) step();

        // Reset mid-drain: the rd=9 write must never be issued.
        rs1_addr = 7; rs2_addr = 9;
        rd9_writes = 0;
        push_alu(7, 32'h33); push_ld(9, 32'h44); step();
        idle(); step();
        rst = 1; step();
        rst = 0; repeat (3) step();
        check("rd9_never_written", 64'(rd9_writes), 64'd0);

        // Steady enqueue/dequeue at count 2 for 8 cycles.
        rs1_addr = 2; rs2_addr = 4;
        idle(); wb_stall = 1; push_alu(2, 32'hC0); push_ld(4, 32'hC1); step();
        for (int i = 0; i < 8; i++) begin
            idle(); push_alu(AW'(2 + 2 * (i % 2)), DW'(32'hD0 + i)); step();
        end
        idle(); repeat (3) step();

        // Random traffic over a small register range to exercise lookups.
        for (int i = 0; i < 80; i++) begin
            idle();
            rs1_addr = AW'($urandom_range(0, 3));
            rs2_addr = AW'($urandom_range(0, 3));
            wb_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) push_alu(AW'($urandom_range(0, 3)), DW'($urandom));
            if ($urandom_range(0, 1) == 1) push_ld(AW'($urandom_range(0, 3)), DW'($urandom));
            step();
        end
        idle(); repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
